// File: rtl/uart_pkg.sv
// Purpose: shared UART definitions (rates, frame format, FSM encoding) used by the receiver and transmitter.
// Latency: n/a (constants, types and pure functions only).
// Backpressure: n/a.
package uart_pkg;

    // Default line configuration
    localparam int unsigned DEF_BASE_FREQ = 50_000_000;
    localparam int unsigned DEF_BAUD_RATE = 115_200;

    // Frame format: 1 start, 8 data LSB first, 1 parity, 1 stop
    localparam int unsigned DATA_BITS   = 8;
    localparam bit          PARITY_EVEN = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_HIGH
    } uart_state_e;

    // Clocks per bit, truncating division
    function automatic int unsigned calc_cpb(input int unsigned base_freq,
                                             input int unsigned baud_rate);
        return base_freq / baud_rate;
    endfunction

    // Clocks to mid-bit, used to centre the start-bit sample
    function automatic int unsigned calc_half(input int unsigned base_freq,
                                              input int unsigned baud_rate);
        return calc_cpb(base_freq, baud_rate) / 2;
    endfunction

    // Counter width able to hold cpb-1
    function automatic int unsigned cnt_width(input int unsigned cpb);
        return (cpb > 1) ? $clog2(cpb) : 1;
    endfunction

    // Parity bit the transmitter places after the data byte
    function automatic logic calc_parity(input logic [DATA_BITS-1:0] d);
        return PARITY_EVEN ? (^d) : ~(^d);
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Purpose: receiver bus bundle; master = receiver (consumes serial_in, drives byte/flags), slave = consumer.
// Latency: n/a (wiring only).
// Backpressure: none; data_valid is a fire-and-forget one-cycle pulse.
interface uart_rx_if;
    import uart_pkg::*;

    logic                 serial_in;   // asynchronous line, idle high
    logic [DATA_BITS-1:0] data_out;    // last received byte
    logic                 data_valid;  // one-cycle frame-complete pulse
    logic                 parity_err;  // parity mismatch on last frame
    logic                 frame_err;   // stop bit low on last frame
    logic                 busy;        // receiver FSM not idle

    modport master (
        input  serial_in,
        output data_out, data_valid, parity_err, frame_err, busy
    );

    modport slave (
        output serial_in,
        input  data_out, data_valid, parity_err, frame_err, busy
    );
endinterface

// File: rtl/sync_2ff.sv
// Purpose: 1-bit two-flop synchronizer; ports clk, rst (sync, active-high), d_i (async in), q_o (synced out).
// Latency: 2 clk cycles from d_i to q_o.
// Backpressure: none.
module sync_2ff #(
    parameter bit RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);
    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/uart_rx.sv
// Purpose: UART receiver (8E1); ports clk, rst (sync, active-high), bus (uart_rx_if.master: serial_in in; data_out/data_valid/parity_err/frame_err/busy out).
// Latency: data_valid pulses 3 + HALF + 10*CPB clocks after serial_in falls (2 sync + 1 detect + sampling).
// Backpressure: none; the consumer must take data_out on the data_valid pulse, flags hold until the next pulse.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned BASE_FREQ = DEF_BASE_FREQ,
    parameter int unsigned BAUD_RATE = DEF_BAUD_RATE
) (
    input  logic       clk,
    input  logic       rst,
    uart_rx_if.master  bus
);
    localparam int unsigned CPB   = calc_cpb(BASE_FREQ, BAUD_RATE);
    localparam int unsigned HALF  = calc_half(BASE_FREQ, BAUD_RATE);
    localparam int unsigned CNT_W = cnt_width(CPB);

    localparam logic [CNT_W-1:0] CPB_M1  = CNT_W'(CPB - 1);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(HALF - 1);
    localparam logic [2:0]       LAST_IDX = 3'(DATA_BITS - 1);

    logic line;

    // Idle-high reset value so leaving reset never looks like a start bit
    sync_2ff #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (bus.serial_in),
        .q_o (line)
    );

    uart_state_e          state_q,   state_d;
    logic [CNT_W-1:0]     cnt_q,     cnt_d;
    logic [2:0]           idx_q,     idx_d;
    logic [DATA_BITS-1:0] shift_q,   shift_d;
    logic                 par_mis_q, par_mis_d;
    logic                 frame_done;

    logic [DATA_BITS-1:0] data_out_q;
    logic                 data_valid_q;
    logic                 parity_err_q;
    logic                 frame_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            par_mis_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            par_mis_q <= par_mis_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        par_mis_d  = par_mis_q;
        frame_done = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!line) begin
                    state_d = ST_START;
                end
            end

            ST_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    // A start bit that is gone by mid-bit was a glitch
                    if (!line) begin
                        state_d = ST_DATA;
                        idx_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_DATA: begin
                if (cnt_q == CPB_M1) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = line;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_PARITY;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_PARITY: begin
                if (cnt_q == CPB_M1) begin
                    cnt_d     = '0;
                    par_mis_d = (line != calc_parity(shift_q));
                    state_d   = ST_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_STOP: begin
                if (cnt_q == CPB_M1) begin
                    cnt_d      = '0;
                    frame_done = 1'b1;
                    // Low stop bit: wait out the break so it cannot start a new frame
                    state_d    = line ? ST_IDLE : ST_WAIT_HIGH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_WAIT_HIGH: begin
                cnt_d = '0;
                if (line) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    // Byte and both flags commit together on the stop sample, visible the following cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            data_valid_q <= frame_done;
            if (frame_done) begin
                data_out_q   <= shift_q;
                parity_err_q <= par_mis_q;
                frame_err_q  <= ~line;
            end
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.data_valid = data_valid_q;
    assign bus.parity_err = parity_err_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.busy       = (state_q != ST_IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Purpose: directed self-checking bench for uart_rx at default rates (CPB=434, HALF=217).
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_rx;
    localparam int CPB  = 434;
    localparam int HALF = 217;
    // Fall of serial_in to visible data_valid: 2 sync + 1 detect + HALF + 10*CPB
    localparam int LAT_MIN = 4557;   // 10.5 * CPB
    localparam int LAT_MAX = 4561;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    int   n_vec = 0;
    int   n_err = 0;

    int         v_cyc[$];
    logic [7:0] v_dat[$];
    logic       v_pe[$];
    logic       v_fe[$];

    uart_rx_if bus();

    uart_rx dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every cycle data_valid is high, so a stretched pulse shows up as an extra entry
    always @(negedge clk) begin
        if (bus.data_valid === 1'b1) begin
            v_cyc.push_back(cyc);
            v_dat.push_back(bus.data_out);
            v_pe.push_back(bus.parity_err);
            v_fe.push_back(bus.frame_err);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        bus.serial_in = b;
        repeat (CPB) tick();
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, output int fall_cyc);
        fall_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(par);
        drive_bit(stop);
    endtask

    initial begin
        int base;
        int fall;
        int lat;
        int gap;
        logic [7:0] rd;

        bus.serial_in = 1'b1;
        rst = 1'b1;
        repeat (3) tick();
        check("rst_data_out",   bus.data_out,   8'h00);
        check("rst_data_valid", bus.data_valid, 1'b0);
        check("rst_parity_err", bus.parity_err, 1'b0);
        check("rst_frame_err",  bus.frame_err,  1'b0);
        check("rst_busy",       bus.busy,       1'b0);
        rst = 1'b0;
        repeat (10) tick();

        // 0xA5: four ones -> parity 0, good stop
        base = v_dat.size();
        send_frame(8'hA5, 1'b0, 1'b1, fall);
        repeat (5) tick();
        check("a5_pulse_count", v_dat.size() - base, 1);
        lat = v_cyc[base] - fall;
        check("a5_latency_window", (lat >= LAT_MIN && lat <= LAT_MAX), 1'b1);
        check("a5_data",       v_dat[base], 8'hA5);
        check("a5_parity_err", v_pe[base],  1'b0);
        check("a5_frame_err",  v_fe[base],  1'b0);
        check("a5_idle_busy",  bus.busy,    1'b0);

        // 0x01: one set bit needs parity 1, send 0
        base = v_dat.size();
        send_frame(8'h01, 1'b0, 1'b1, fall);
        repeat (5) tick();
        check("p01_pulse_count", v_dat.size() - base, 1);
        check("p01_data",       v_dat[base], 8'h01);
        check("p01_parity_err", v_pe[base],  1'b1);
        check("p01_frame_err",  v_fe[base],  1'b0);
        repeat (50) tick();
        check("p01_parity_hold", bus.parity_err, 1'b1);

        // 0x3C with low stop bit, then a 3*CPB break
        base = v_dat.size();
        send_frame(8'h3C, 1'b0, 1'b0, fall);
        repeat (3 * CPB) tick();
        check("brk_busy_during", bus.busy, 1'b1);
        check("brk_pulse_count", v_dat.size() - base, 1);
        check("brk_data",       v_dat[base], 8'h3C);
        check("brk_frame_err",  v_fe[base],  1'b1);
        check("brk_parity_err", v_pe[base],  1'b0);
        bus.serial_in = 1'b1;
        repeat (4) tick();
        check("brk_busy_after_high", bus.busy, 1'b0);
        check("brk_no_new_frame", v_dat.size() - base, 1);

        // Short low glitch: start sample at mid-bit sees high again
        base = v_dat.size();
        bus.serial_in = 1'b0;
        repeat (100) tick();
        check("glitch_busy_start", bus.busy, 1'b1);
        bus.serial_in = 1'b1;
        repeat (HALF + 3) tick();
        check("glitch_busy_released", bus.busy, 1'b0);
        check("glitch_no_pulse", v_dat.size() - base, 0);

        // Reset in the middle of data bit 4 of 0xA5
        base = v_dat.size();
        rd = 8'hA5;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(rd[i]);
        bus.serial_in = rd[4];
        repeat (CPB / 2) tick();
        check("mid_busy_before_rst", bus.busy, 1'b1);
        rst = 1'b1;
        bus.serial_in = 1'b1;
        tick();
        check("mid_rst_data_out",   bus.data_out,   8'h00);
        check("mid_rst_data_valid", bus.data_valid, 1'b0);
        check("mid_rst_parity_err", bus.parity_err, 1'b0);
        check("mid_rst_frame_err",  bus.frame_err,  1'b0);
        check("mid_rst_busy",       bus.busy,       1'b0);
        rst = 1'b0;
        repeat (CPB * 7) tick();
        check("mid_rst_no_pulse", v_dat.size() - base, 0);
        base = v_dat.size();
        send_frame(8'h3C, 1'b0, 1'b1, fall);
        repeat (5) tick();
        check("post_rst_pulse_count", v_dat.size() - base, 1);
        check("post_rst_data",       v_dat[base], 8'h3C);
        check("post_rst_parity_err", v_pe[base],  1'b0);
        check("post_rst_frame_err",  v_fe[base],  1'b0);

        // Back-to-back frames, next start bit immediately after stop bit
        base = v_dat.size();
        send_frame(8'h00, 1'b0, 1'b1, fall);
        send_frame(8'hFF, 1'b0, 1'b1, fall);
        repeat (5) tick();
        check("b2b_pulse_count", v_dat.size() - base, 2);
        gap = v_cyc[base + 1] - v_cyc[base];
        check("b2b_gap", (gap >= 11 * CPB - 1 && gap <= 11 * CPB + 1), 1'b1);
        check("b2b_data0", v_dat[base],     8'h00);
        check("b2b_data1", v_dat[base + 1], 8'hFF);
        check("b2b_errs0", {v_pe[base], v_fe[base]}, 2'b00);
        check("b2b_errs1", {v_pe[base + 1], v_fe[base + 1]}, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter BASE_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115_200, line bit rate in bit/s.
REQ-003 Port clk  input  1  system clock; all logic on rising edge.
REQ-004 Port rst  input  1  reset; one clock, reset synchronous and active-high.
REQ-005 Port serial_in  input  1  asynchronous UART line, idle high.
REQ-006 Port data_out  output  8  last received data byte.
REQ-007 Port data_valid  output  1  one-cycle pulse; frame complete and data_out/flags updated.
REQ-008 Port parity_err  output  1  even-parity mismatch on last frame.
REQ-009 Port frame_err  output  1  stop bit sampled low on last frame.
REQ-010 Port busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-011 Frame format SHALL be 1 start (0), 8 data bits LSB first, 1 even-parity bit, 1 stop (1); this matches the team's TX.
REQ-012 CPB SHALL equal BASE_FREQ/BAUD_RATE with integer division (434 at defaults); HALF SHALL equal CPB/2 (217).
REQ-013 serial_in SHALL pass through a 2-flop synchronizer before any use; all sampling uses the synchronized value.
REQ-014 FSM states SHALL be IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
REQ-015 IDLE: synchronized line low SHALL move to START with the bit counter cleared.
REQ-016 START: at counter == HALF-1 the line is sampled; low -> DATA with counter cleared and bit index 0; high -> IDLE with no output change (glitch rejection).
REQ-017 DATA: the counter runs 0..CPB-1; at CPB-1 the line is sampled into data bit [index] and the counter wraps; after index 7 -> PARITY.
REQ-018 PARITY: sample at CPB-1; the mismatch flag is set when the sampled bit differs from the XOR of the 8 data bits; then -> STOP.
REQ-019 STOP: sample at CPB-1; in the next cycle data_out, parity_err and frame_err SHALL update together and data_valid SHALL pulse for exactly one cycle.
REQ-020 STOP: a high sample -> IDLE; a low sample sets frame_err and -> WAIT_HIGH.
REQ-021 WAIT_HIGH SHALL remain until the synchronized line is high, then -> IDLE; a held-low (break) line SHALL NOT start new frames.
REQ-022 data_valid SHALL pulse even when an error flag is set; data_out SHALL always carry the sampled byte.
REQ-023 parity_err and frame_err SHALL hold their values until the next data_valid.
REQ-024 A falling edge arriving in the cycle the FSM re-enters IDLE SHALL be accepted, so back-to-back frames with no idle gap are received.
REQ-025 The counter SHALL be wide enough for CPB-1 and SHALL never exceed CPB-1.

Reset
REQ-026 While rst is high the FSM SHALL go to IDLE, and the counter and bit index SHALL clear.
REQ-027 While rst is high data_out SHALL be 0x00, and data_valid, parity_err, frame_err and busy SHALL be 0.
REQ-028 While rst is high both synchronizer flops SHALL be 1.
REQ-029 Reset asserted mid-frame SHALL abort the frame with no data_valid pulse.

Structure
REQ-030 Shared package uart_pkg SHALL hold BASE_FREQ/BAUD_RATE defaults, the CPB/HALF derivation, the frame constants (8 data bits, even parity) and the state encoding, for reuse by TX.
REQ-031 The synchronizer SHALL be a separate sub-module sync_2ff (1-bit, reset value parameter set to 1).

Verification
REQ-032 Verification SHALL use the default parameters, so CPB = 434.
REQ-033 Frame 0xA5 with parity 0 and stop 1: data_out=0xA5, one data_valid pulse 10.5*CPB..10.5*CPB+4 clocks after the line falls, both error flags 0.
REQ-034 Frame 0x01 with parity bit 0: data_out=0x01, parity_err=1, frame_err=0, one data_valid pulse.
REQ-035 Frame 0x3C with stop bit low, then line held low for 3*CPB: frame_err=1, a single data_valid pulse, busy stays high until the line returns high.
REQ-036 Line low for 100 clocks, then high: no data_valid, busy returns to 0 within HALF+3 clocks.
REQ-037 rst pulsed during data bit 4: all outputs 0 next cycle; following frame 0x3C gives data_out=0x3C with no errors.
REQ-038 Back-to-back frames 0x00 then 0xFF with no idle gap: two data_valid pulses, 11*CPB apart (+/-1), with data 0x00 then 0xFF and no errors.
